// File: rtl/mem_mux_pkg.sv
// Shared types and default sizing for the loader/processor memory port multiplexer.
package mem_mux_pkg;

    localparam int unsigned DEF_NCH       = 2;
    localparam int unsigned DEF_AW        = 32;
    localparam int unsigned DEF_DW        = 32;
    localparam int unsigned DEF_MAX_OUTST = 4;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        DRAIN_R = 2'd1,
        RUN     = 2'd2,
        DRAIN_I = 2'd3
    } mode_e;

endpackage

// File: rtl/mem_outst_cnt.sv
// Per-channel outstanding-read counter with a sticky flag for read data nobody asked for.
module mem_outst_cnt
    import mem_mux_pkg::*;
#(
    parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_sat_c,
    output logic o_idle_c,
    output logic o_err
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // A return with nothing outstanding is dropped from the count but flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_dec && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
            if (i_inc && !i_dec) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (i_dec && !i_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_sat_c  = (r_cnt == CW'(MAX_OUTST));
    assign o_idle_c = (r_cnt == '0);
    assign o_err    = r_err;

endmodule

// File: rtl/mem_port_mux.sv
// Hands the memory channels to either the loader or the processor, draining
// outstanding reads before ownership changes.
module mem_port_mux
    import mem_mux_pkg::*;
#(
    parameter int unsigned NCH       = DEF_NCH,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ini,
    input  logic [NCH-1:0]    ini_PROC_REQ,
    input  logic [NCH-1:0]    ini_WE,
    input  logic [NCH*AW-1:0] ini_ADDR,
    input  logic [NCH*DW-1:0] ini_WDATA,
    output logic [NCH-1:0]    ini_MEM_RDY,
    output logic [NCH-1:0]    ini_VALID,
    output logic [NCH*DW-1:0] ini_RDATA,
    input  logic [NCH-1:0]    proc_req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    mem_rdy,
    output logic [NCH-1:0]    valid,
    output logic [NCH*DW-1:0] rdata,
    output logic [NCH-1:0]    m_PROC_REQ,
    output logic [NCH-1:0]    m_WE,
    output logic [NCH*AW-1:0] m_ADDR,
    output logic [NCH*DW-1:0] m_WDATA,
    input  logic [NCH-1:0]    m_MEM_RDY,
    input  logic [NCH-1:0]    m_VALID,
    input  logic [NCH*DW-1:0] m_RDATA,
    output logic              proc_run,
    output logic [1:0]        mode,
    output logic [NCH-1:0]    err
);

    mode_e          r_state;
    mode_e          w_next;
    logic           r_proc_run;
    logic           w_ldr_own;
    logic           w_fwd;
    logic           w_all_idle;
    logic [NCH-1:0] w_sat;
    logic [NCH-1:0] w_idle;
    logic [NCH-1:0] w_rdy;
    logic [NCH-1:0] w_vld;
    logic [NCH-1:0] w_rd_acc;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= INIT;
            r_proc_run <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_proc_run <= (w_next == RUN);
        end
    end

    // Ownership follows the state; drain states block new requests until counts reach zero.
    always_comb begin
        w_next    = r_state;
        w_ldr_own = (r_state == INIT) || (r_state == DRAIN_R);
        w_fwd     = RSTn && ((r_state == INIT) || (r_state == RUN));
        case (r_state)
            INIT:    if (!ini) w_next = DRAIN_R;
            DRAIN_R: if (ini) w_next = INIT;
                     else if (w_all_idle) w_next = RUN;
            RUN:     if (ini) w_next = DRAIN_I;
            DRAIN_I: if (!ini) w_next = RUN;
                     else if (w_all_idle) w_next = INIT;
            default: w_next = INIT;
        endcase
    end

    assign w_all_idle = &w_idle;
    assign mode       = r_state;
    assign proc_run   = r_proc_run;

    // A saturated channel holds off every request so the owner never sees a silent accept.
    assign w_rdy      = {NCH{w_fwd}} & m_MEM_RDY & ~w_sat;
    assign m_PROC_REQ = {NCH{w_fwd}} & ~w_sat & (w_ldr_own ? ini_PROC_REQ : proc_req);
    assign m_WE       = w_ldr_own ? ini_WE    : we;
    assign m_ADDR     = w_ldr_own ? ini_ADDR  : addr;
    assign m_WDATA    = w_ldr_own ? ini_WDATA : wdata;
    assign w_rd_acc   = m_PROC_REQ & m_MEM_RDY & ~m_WE;

    assign w_vld       = {NCH{RSTn}} & m_VALID;
    assign ini_MEM_RDY = w_ldr_own ? w_rdy   : '0;
    assign mem_rdy     = w_ldr_own ? '0      : w_rdy;
    assign ini_VALID   = w_ldr_own ? w_vld   : '0;
    assign valid       = w_ldr_own ? '0      : w_vld;
    assign ini_RDATA   = w_ldr_own ? m_RDATA : '0;
    assign rdata       = w_ldr_own ? '0      : m_RDATA;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mem_outst_cnt #(
            .MAX_OUTST (MAX_OUTST)
        ) u_cnt (
            .clk      (CLK),
            .rst_n    (RSTn),
            .i_inc    (w_rd_acc[g]),
            .i_dec    (m_VALID[g]),
            .o_sat_c  (w_sat[g]),
            .o_idle_c (w_idle[g]),
            .o_err    (err[g])
        );
    end

endmodule

// File: doc/mem_port_mux.md
MEM_PORT_MUX -- requirements
Module: mem_port_mux

Interface
REQ-001 Parameters SHALL be, one per line:
  NCH, 2, number of memory channels (1..8)
  AW, 32, address width
  DW, 32, data width
  MAX_OUTST, 4, maximum outstanding reads per channel (1..15)
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports, one per line:
  CLK  in  1  clock
  RSTn  in  1  asynchronous active-low reset
  ini  in  1  loader mode request
  ini_PROC_REQ / ini_WE  in  NCH  loader request / write enable, per channel
  ini_ADDR  in  NCH*AW  loader address
  ini_WDATA  in  NCH*DW  loader write data
  ini_MEM_RDY / ini_VALID  out  NCH  loader accept / read-data valid
  ini_RDATA  out  NCH*DW  loader read data
  proc_req / we  in  NCH  processor request / write enable
  addr  in  NCH*AW  processor address
  wdata  in  NCH*DW  processor write data
  mem_rdy / valid  out  NCH  processor accept / read-data valid
  rdata  out  NCH*DW  processor read data
  m_PROC_REQ / m_WE  out  NCH  memory request / write enable
  m_ADDR  out  NCH*AW  memory address
  m_WDATA  out  NCH*DW  memory write data
  m_MEM_RDY / m_VALID  in  NCH  memory accept / read-data valid
  m_RDATA  in  NCH*DW  memory read data
  proc_run  out  1  processor enable (replaces clock gating)
  mode  out  2  current FSM state
  err  out  NCH  sticky protocol error

Function
REQ-003 Handshake: a request SHALL be accepted in a cycle where m_PROC_REQ and m_MEM_RDY are both high; each accepted read (WE=0) SHALL receive exactly one m_VALID later; writes SHALL receive no VALID.
REQ-004 FSM states SHALL be INIT=0, DRAIN_R=1, RUN=2, DRAIN_I=3, driven on mode.
REQ-005 Transitions SHALL be: INIT->DRAIN_R on ini=0; DRAIN_R->RUN when all counts are 0 and ini=0; DRAIN_R->INIT on ini=1; RUN->DRAIN_I on ini=1; DRAIN_I->INIT when all counts are 0 and ini=1; DRAIN_I->RUN on ini=0.
REQ-006 The owner SHALL be the loader in INIT/DRAIN_R and the processor in RUN/DRAIN_I.
REQ-007 In INIT/RUN, the owner's request, WE, address and wdata SHALL be forwarded combinationally to m_*; the non-owner's request signals SHALL be ignored.
REQ-008 In DRAIN_R/DRAIN_I, m_PROC_REQ SHALL be 0 and both sides' MEM_RDY SHALL be 0.
REQ-009 The owner's MEM_RDY SHALL be m_MEM_RDY AND (count<MAX_OUTST); at count=MAX_OUTST, a read request SHALL NOT be forwarded; the non-owner's MEM_RDY SHALL be 0.
REQ-010 m_VALID/m_RDATA SHALL route combinationally to the owner; the non-owner's VALID SHALL be 0 and its RDATA SHALL be 0.
REQ-011 Per-channel count width SHALL be $clog2(MAX_OUTST+1); it SHALL increment on an accepted read, decrement on m_VALID, and hold when both occur in the same cycle.
REQ-012 m_VALID with count=0 SHALL leave count at 0 and SHALL set err[ch]; only reset SHALL clear err.
REQ-013 proc_run SHALL be high only in RUN, and SHALL go low in the cycle after ini rises.

Reset
REQ-014 On RSTn low, the state SHALL be INIT, counts 0, err 0, proc_run 0, and all m_PROC_REQ, MEM_RDY and VALID outputs 0, asynchronously.
REQ-015 Reset asserted mid-transaction SHALL discard outstanding counts; a VALID arriving after reset release with count 0 SHALL set err.

Structure
REQ-016 Package mem_mux_pkg SHALL hold the mode_e enum (INIT, DRAIN_R, RUN, DRAIN_I) and the default parameter constants.
REQ-017 The per-channel counter and err flag SHALL be the sub-module mem_outst_cnt, instantiated NCH times; the FSM and muxing SHALL stay in the top.

Verification
REQ-018 Load then run: NCH=2; in INIT, write 0x1234 to ch0 at 0x10; drop ini; processor reads 0x10 -> VALID with rdata=0x1234; mode goes 0->1->2; proc_run=1.
REQ-019 Drain: in RUN, 3 reads outstanding on ch1; raise ini -> mode=3, mem_rdy=0, ini_MEM_RDY=0 until 3rd VALID arrives at the processor, then mode=0.
REQ-020 Saturation: MAX_OUTST=4 and memory withholding VALID; 4 reads accepted -> MEM_RDY=0 on the 5th; one VALID arrives -> MEM_RDY=1 the next cycle.
REQ-021 Abort drain: in DRAIN_I with count=2, drop ini -> mode=2 in the next cycle, and the pending VALIDs go to the processor.
REQ-022 Error/reset: m_VALID with count=0 -> err[ch]=1 and sticky; assert RSTn low mid-read -> mode=0 and err=0 immediately.
